// File: rtl/frontier_pkg.sv
// Shared defaults, entry layout and round-robin helper for the frontier write front-end.
package frontier_pkg;

  localparam int unsigned DEF_W_ADDR = 32;
  localparam int unsigned DEF_W_COST = 32;

  typedef struct packed {
    logic [DEF_W_ADDR-1:0] node_addr;
    logic [DEF_W_COST-1:0] cost;
  } entry_t;

  // Pointer value that follows a grant, wrapping at the channel count.
  function automatic int unsigned rr_next(input int unsigned grant, input int unsigned num_ch);
    return (grant + 1) % num_ch;
  endfunction

endpackage

// File: rtl/frontier_mux_fifo.sv
// Staging FIFO: sync-read RAM whose read port loads a single valid/ready output register.
module frontier_mux_fifo #(
  parameter int unsigned W_DATA = 64,
  parameter int unsigned W_A    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              enq_i,
  input  logic [W_DATA-1:0] enq_data_i,
  output logic              full_o,
  output logic              out_valid_o,
  output logic [W_DATA-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [W_A:0]      occupancy_o
);

  localparam int unsigned DEPTH = 1 << W_A;
  localparam int unsigned W_CNT = W_A + 1;

  logic [W_DATA-1:0] mem [DEPTH];
  logic [W_A-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [W_CNT-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              out_valid_q, out_valid_d;
  logic [W_DATA-1:0] out_data_q;
  logic              do_enq, rd_en;

  // Read whenever the output register is free or draining this cycle, so there is no bubble.
  always_comb begin
    do_enq      = enq_i && !full_q && !flush_i;
    rd_en       = (count_q != '0) && (!out_valid_q || out_ready_i) && !flush_i;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    if (flush_i) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (do_enq) wptr_d = wptr_q + W_A'(1);
      if (rd_en)  rptr_d = rptr_q + W_A'(1);
      count_d     = count_q + W_CNT'(do_enq) - W_CNT'(rd_en);
      out_valid_d = rd_en || (out_valid_q && !out_ready_i);
    end
    full_d = (count_d == W_CNT'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      if (rd_en) out_data_q <= mem[rptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem[wptr_q] <= enq_data_i;
  end

  assign full_o      = full_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign occupancy_o = count_q + W_CNT'(out_valid_q);

endmodule

// File: rtl/frontier_mux.sv
// N-channel round-robin write front-end for the frontier heap, with pop gating.
// Define FRONTIER_MUX_STAT_EN to build the saturating accept/stall counters.
module frontier_mux
  import frontier_pkg::*;
#(
  parameter int unsigned W_ADDR   = DEF_W_ADDR,
  parameter int unsigned W_COST   = DEF_W_COST,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned W_FIFO_A = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_CH-1:0]          wr_valid,
  output logic [NUM_CH-1:0]          wr_ready,
  input  logic [NUM_CH*W_ADDR-1:0]   wr_node_addr,
  input  logic [NUM_CH*W_COST-1:0]   wr_cost,
  input  logic                       read_req_valid,
  output logic                       read_req_ready,
  output logic                       read_data_valid,
  output logic [W_ADDR-1:0]          read_node_addr,
  output logic [W_COST-1:0]          read_cost,
  output logic                       read_empty,
  output logic                       heap_write_valid,
  input  logic                       heap_write_ready,
  output logic [W_ADDR+W_COST-1:0]   heap_write_data,
  output logic                       heap_read_req_valid,
  input  logic                       heap_read_req_ready,
  input  logic                       heap_read_data_valid,
  input  logic [W_ADDR+W_COST-1:0]   heap_read_data,
  input  logic                       heap_read_empty,
  input  logic                       reset_state,
  output logic [W_FIFO_A:0]          occupancy,
  output logic [31:0]                stat_accepts,
  output logic [31:0]                stat_stalls
);

  localparam int unsigned W_ENTRY = W_ADDR + W_COST;
  localparam int unsigned W_CH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [W_CH-1:0]    rr_q, rr_d;
  logic               en_q;
  logic [NUM_CH-1:0]  grant_oh;
  logic [W_CH-1:0]    grant_idx;
  logic               grant_any;
  logic [W_ENTRY-1:0] grant_data;
  logic               fifo_full;
  logic               occ_zero;
  int unsigned        idx;
  logic [W_CH-1:0]    idx_w;

  // First requester at or above the pointer wins; nothing is granted while full or flushing.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx   = (32'(rr_q) + k) % NUM_CH;
      idx_w = W_CH'(idx);
      if (!grant_any && wr_valid[idx_w] && en_q && !fifo_full && !reset_state) begin
        grant_any       = 1'b1;
        grant_idx       = idx_w;
        grant_oh[idx_w] = 1'b1;
      end
    end
    rr_d = rr_q;
    if (reset_state)    rr_d = '0;
    else if (grant_any) rr_d = W_CH'(rr_next(32'(grant_idx), NUM_CH));
  end

  assign grant_data = {wr_node_addr[32'(grant_idx)*W_ADDR +: W_ADDR],
                       wr_cost[32'(grant_idx)*W_COST +: W_COST]};

  // en_q keeps writers and pops off until the first clock after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_q <= '0;
      en_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      en_q <= 1'b1;
    end
  end

  frontier_mux_fifo #(
    .W_DATA (W_ENTRY),
    .W_A    (W_FIFO_A)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (RST_N),
    .flush_i     (reset_state),
    .enq_i       (grant_any),
    .enq_data_i  (grant_data),
    .full_o      (fifo_full),
    .out_valid_o (heap_write_valid),
    .out_data_o  (heap_write_data),
    .out_ready_i (heap_write_ready),
    .occupancy_o (occupancy)
  );

  // A pop may only reach the heap once every accepted insert has been handed over.
  assign occ_zero            = (occupancy == '0);
  assign wr_ready            = grant_oh;
  assign heap_read_req_valid = read_req_valid && occ_zero && en_q;
  assign read_req_ready      = heap_read_req_ready && occ_zero && en_q;
  assign read_empty          = heap_read_empty && occ_zero;
  assign read_data_valid     = heap_read_data_valid;
  assign read_node_addr      = heap_read_data[W_ENTRY-1 -: W_ADDR];
  assign read_cost           = heap_read_data[W_COST-1:0];

`ifdef FRONTIER_MUX_STAT_EN
  logic [31:0] acc_q, acc_d, stl_q, stl_d;

  always_comb begin
    acc_d = acc_q;
    stl_d = stl_q;
    if (reset_state) begin
      acc_d = '0;
      stl_d = '0;
    end else begin
      if (grant_any && (acc_q != '1))                 acc_d = acc_q + 32'd1;
      if ((|wr_valid) && !grant_any && (stl_q != '1)) stl_d = stl_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q <= '0;
      stl_q <= '0;
    end else begin
      acc_q <= acc_d;
      stl_q <= stl_d;
    end
  end

  assign stat_accepts = acc_q;
  assign stat_stalls  = stl_q;
`else
  assign stat_accepts = '0;
  assign stat_stalls  = '0;
`endif

endmodule

// File: tb/tb_frontier_mux.sv
// Randomised scoreboard bench for frontier_mux (4 channels, 4-deep staging FIFO).
module tb_frontier_mux;

  localparam int unsigned W_ADDR   = 16;
  localparam int unsigned W_COST   = 12;
  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned W_FIFO_A = 2;
  localparam int unsigned W_E      = W_ADDR + W_COST;
  localparam int          DEPTH    = 1 << W_FIFO_A;

  logic                     CLK = 1'b0;
  logic                     RST_N;
  logic [NUM_CH-1:0]        wr_valid;
  logic [NUM_CH-1:0]        wr_ready;
  logic [NUM_CH*W_ADDR-1:0] wr_node_addr;
  logic [NUM_CH*W_COST-1:0] wr_cost;
  logic                     read_req_valid, read_req_ready, read_data_valid, read_empty;
  logic [W_ADDR-1:0]        read_node_addr;
  logic [W_COST-1:0]        read_cost;
  logic                     heap_write_valid, heap_write_ready;
  logic [W_E-1:0]           heap_write_data;
  logic                     heap_read_req_valid, heap_read_req_ready, heap_read_data_valid;
  logic [W_E-1:0]           heap_read_data;
  logic                     heap_read_empty, reset_state;
  logic [W_FIFO_A:0]        occupancy;
  logic [31:0]              stat_accepts, stat_stalls;

  frontier_mux #(
    .W_ADDR(W_ADDR), .W_COST(W_COST), .NUM_CH(NUM_CH), .W_FIFO_A(W_FIFO_A)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_node_addr(wr_node_addr), .wr_cost(wr_cost),
    .read_req_valid(read_req_valid), .read_req_ready(read_req_ready),
    .read_data_valid(read_data_valid), .read_node_addr(read_node_addr),
    .read_cost(read_cost), .read_empty(read_empty),
    .heap_write_valid(heap_write_valid), .heap_write_ready(heap_write_ready),
    .heap_write_data(heap_write_data),
    .heap_read_req_valid(heap_read_req_valid), .heap_read_req_ready(heap_read_req_ready),
    .heap_read_data_valid(heap_read_data_valid), .heap_read_data(heap_read_data),
    .heap_read_empty(heap_read_empty), .reset_state(reset_state),
    .occupancy(occupancy), .stat_accepts(stat_accepts), .stat_stalls(stat_stalls)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W_E-1:0] data;
    int             acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_xfer = -100;
  int   rr_m = 0;
  int   acc_m = 0;
  int   stl_m = 0;
  bit   chk_en = 1'b0;

  bit                ov_m, full_m, drained_m, stall_q;
  int                g_m, head_at;
  logic [NUM_CH-1:0] rdy_m;
  logic [W_E-1:0]    held;
  exp_t              e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: entries leave in acceptance order, each visible 2 cycles after acceptance
  // and no earlier than the cycle after its predecessor left.
  always @(negedge CLK) begin
    if (chk_en) begin
      ov_m = 1'b0;
      if (sb.size() > 0) begin
        head_at = (sb[0].acc + 2 > last_xfer + 1) ? sb[0].acc + 2 : last_xfer + 1;
        ov_m    = (cyc >= head_at);
      end
      full_m = (sb.size() - int'(ov_m)) >= DEPTH;
      g_m    = -1;
      if (!reset_state && !full_m)
        for (int k = 0; k < NUM_CH; k++)
          if (g_m < 0 && wr_valid[(rr_m + k) % NUM_CH]) g_m = (rr_m + k) % NUM_CH;
      rdy_m     = (g_m >= 0) ? NUM_CH'(1 << g_m) : '0;
      drained_m = (sb.size() == 0);
      check("wr_ready", 64'(wr_ready), 64'(rdy_m));
      check("heap_write_valid", 64'(heap_write_valid), 64'(ov_m));
      check("occupancy", 64'(occupancy), 64'(sb.size()));
      check("heap_read_req_valid", 64'(heap_read_req_valid), 64'(read_req_valid && drained_m));
      check("read_req_ready", 64'(read_req_ready), 64'(heap_read_req_ready && drained_m));
      check("read_empty", 64'(read_empty), 64'(heap_read_empty && drained_m));
      check("read_passthru", 64'({read_data_valid, read_node_addr, read_cost}),
            64'({heap_read_data_valid, heap_read_data}));
`ifdef FRONTIER_MUX_STAT_EN
      check("stat_accepts", 64'(stat_accepts), 64'(acc_m));
      check("stat_stalls", 64'(stat_stalls), 64'(stl_m));
`else
      check("stat_accepts", 64'(stat_accepts), 64'd0);
      check("stat_stalls", 64'(stat_stalls), 64'd0);
`endif
      if (reset_state) begin
        sb.delete();
        rr_m  = 0;
        acc_m = 0;
        stl_m = 0;
      end else if (g_m >= 0) begin
        e.data = {wr_node_addr[g_m*W_ADDR +: W_ADDR], wr_cost[g_m*W_COST +: W_COST]};
        e.acc  = cyc;
        sb.push_back(e);
        rr_m = (g_m + 1) % NUM_CH;
        acc_m++;
      end else if (|wr_valid) begin
        stl_m++;
      end
    end
    cyc++;
  end

  // Monitor: pops the scoreboard on every heap write handshake.
  always @(negedge CLK) begin
    #1;
    if (chk_en && !reset_state) begin
      if (stall_q && heap_write_valid) check("hold_data", 64'(heap_write_data), 64'(held));
      if (heap_write_valid && heap_write_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write cycle %0d: got %0h expected none", cyc, heap_write_data);
        end else begin
          check("heap_write_data", 64'(heap_write_data), 64'(sb[0].data));
          void'(sb.pop_front());
          last_xfer = cyc - 1;
        end
      end
      stall_q = heap_write_valid && !heap_write_ready;
      held    = heap_write_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_CH; i++) begin
      wr_node_addr[i*W_ADDR +: W_ADDR] = W_ADDR'($urandom);
      wr_cost[i*W_COST +: W_COST]      = W_COST'($urandom);
    end
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    #1 RST_N = 1'b0;
    sb.delete();
    rr_m  = 0;
    acc_m = 0;
    stl_m = 0;
    wr_valid = '0;
    tick();
    RST_N = 1'b1;
    repeat (2) tick();
    chk_en = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    wr_valid = '0; wr_node_addr = '0; wr_cost = '0;
    read_req_valid = 1'b0; heap_write_ready = 1'b0; heap_read_req_ready = 1'b0;
    heap_read_data_valid = 1'b0; heap_read_data = '0; heap_read_empty = 1'b0; reset_state = 1'b0;
    repeat (3) tick();
    // Outputs while reset is held, with every input trying to provoke activity.
    wr_valid = '1; heap_read_req_ready = 1'b1; read_req_valid = 1'b1; heap_read_empty = 1'b1;
    #1;
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_heap_write_valid", 64'(heap_write_valid), 64'd0);
    check("rst_read_req_ready", 64'(read_req_ready), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_read_empty_1", 64'(read_empty), 64'd1);
    check("rst_stats", 64'({stat_accepts, stat_stalls}), 64'd0);
    heap_read_empty = 1'b0;
    #1 check("rst_read_empty_0", 64'(read_empty), 64'd0);
    wr_valid = '0; read_req_valid = 1'b0;
    tick();
    RST_N = 1'b1;
    repeat (2) tick();
    chk_en = 1'b1;

    // Single write from ch0 with a pending pop request.
    heap_write_ready = 1'b1; read_req_valid = 1'b1;
    wr_node_addr[0 +: W_ADDR] = W_ADDR'(5);
    wr_cost[0 +: W_COST]      = W_COST'(9);
    wr_valid = 4'b0001;
    tick();
    wr_valid = '0;
    repeat (5) tick();
    read_req_valid = 1'b0;

    // Flush to restart the pointer, then two 8-cycle contention bursts.
    reset_state = 1'b1; tick(); reset_state = 1'b0;
    for (int c = 0; c < 8; c++) begin wr_valid = 4'b1111; rand_data(); tick(); end
    for (int c = 0; c < 8; c++) begin wr_valid = (c == 2) ? 4'b1011 : 4'b1111; rand_data(); tick(); end
    wr_valid = '0;
    repeat (4) tick();

    // Fill to capacity against a stalled heap, then drain.
    heap_write_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin wr_valid = 4'b1111; rand_data(); tick(); end
    wr_valid = '0; heap_write_ready = 1'b1;
    repeat (10) tick();

    // Flush with three entries buffered.
    heap_write_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin wr_valid = 4'b0100; rand_data(); tick(); end
    wr_valid = '0;
    reset_state = 1'b1; tick(); reset_state = 1'b0;
    heap_write_ready = 1'b1; wr_valid = 4'b1111; rand_data(); tick();
    wr_valid = '0;
    repeat (4) tick();

    // Random traffic on every input.
    for (int c = 0; c < 600; c++) begin
      wr_valid             = NUM_CH'($urandom);
      rand_data();
      heap_write_ready     = ($urandom_range(0, 3) != 0);
      read_req_valid       = 1'($urandom);
      heap_read_req_ready  = 1'($urandom);
      heap_read_data_valid = 1'($urandom);
      heap_read_data       = W_E'($urandom);
      heap_read_empty      = 1'($urandom);
      reset_state          = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset_state = 1'b0;

    // Async reset in the middle of traffic, then more random traffic and a final drain.
    heap_write_ready = 1'b0; wr_valid = 4'b1111; rand_data(); tick(); tick();
    do_reset();
    for (int c = 0; c < 200; c++) begin
      wr_valid         = NUM_CH'($urandom);
      rand_data();
      heap_write_ready = 1'($urandom);
      tick();
    end
    wr_valid = '0; heap_write_ready = 1'b1;
    repeat (12) tick();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
